// File: rtl/pio_edge_in.sv
// Avalon-MM input PIO: synchronised input bus, per-bit edge capture and
// masked level interrupt. Read data is registered (latency 1).
module pio_edge_in #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int BIT_CLEAR   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int ARM_N = SYNC_STAGES + 1;
  localparam int AW    = $clog2(ARM_N + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_mask;
  logic [WIDTH-1:0]                  r_ecap;
  logic [AW-1:0]                     r_arm_cnt;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_ecap_nxt;
  logic [31:0]      w_rd_nxt;
  logic             w_armed;
  logic             w_wr;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_armed = (r_arm_cnt == AW'(ARM_N));
  assign w_wr    = chipselect & ~write_n;

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = w_s & ~r_prev;
      1:       w_edge = ~w_s & r_prev;
      default: w_edge = w_s ^ r_prev;
    endcase
  end

  // Clear first, then OR in new edges so a same-cycle set wins.
  always_comb begin
    w_clr = '0;
    if (w_wr && address == 2'd3)
      w_clr = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
    w_ecap_nxt = (r_ecap & ~w_clr) | (w_armed ? w_edge : '0);
  end

  always_comb begin
    w_rd_nxt = '0;
    case (address)
      2'd0:    w_rd_nxt = 32'(w_s);
      2'd2:    w_rd_nxt = 32'(r_mask);
      2'd3:    w_rd_nxt = 32'(r_ecap);
      default: w_rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_prev    <= '0;
      r_mask    <= '0;
      r_ecap    <= '0;
      r_arm_cnt <= '0;
      readdata  <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_s;
      // Arming holds off capture until the synchroniser and prev hold real input.
      if (!w_armed) r_arm_cnt <= r_arm_cnt + AW'(1);
      if (w_wr && address == 2'd2) r_mask <= writedata[WIDTH-1:0];
      r_ecap   <= w_ecap_nxt;
      readdata <= w_rd_nxt;
    end
  end

  assign irq = |(r_ecap & r_mask);

endmodule

// File: doc/pio_edge_in.md
# pio_edge_in

Parametrised Avalon-MM input PIO for the Nios II system: samples a WIDTH-bit external input bus through a synchroniser, detects per-bit edges into a sticky edge-capture register, and raises a level interrupt gated by a per-bit mask. It is the edge-capable, interrupt-capable successor to the plain input-only PIO and sits on the Nios II data master bus with its irq wired to the CPU interrupt controller.

## Interface
Parameters:
- WIDTH, 2, input bus width, 1..32.
- SYNC_STAGES, 2, synchroniser flops on in_port, 2..4.
- EDGE_TYPE, 0, edge detected: 0 rising, 1 falling, 2 any.
- BIT_CLEAR, 1, 1: edgecapture write-1-to-clear per bit; 0: any write to edgecapture clears all bits.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active high.

## Operation
- Register map: 0 data (RO, synchronised input), 1 reserved (reads 0, writes ignored), 2 irqmask (RW, WIDTH bits), 3 edgecapture (RW-clear, WIDTH bits). Bits above WIDTH read 0; writes to them ignored.
- Synchroniser: sync[0] <= in_port, sync[i] <= sync[i-1]; s = sync[SYNC_STAGES-1]. prev <= s every cycle.
- Edge per bit: rising = s & ~prev; falling = ~s & prev; any = s ^ prev; select by EDGE_TYPE.
- Arming: counter after reset counts SYNC_STAGES+1 clocks; edges are ignored until it saturates (prevents spurious capture when inputs are high at reset). Counter then holds; only reset re-arms it.
- edgecapture: bit set on detected edge (armed only); cleared by write (chipselect & ~write_n & address==3) per BIT_CLEAR. Same-cycle set and clear on one bit: set wins.
- irqmask: loaded from writedata[WIDTH-1:0] on write to address 2.
- irq = |(edgecapture & irqmask), built only from registers (glitch-free), no extra stage.
- readdata: registered every clock from address mux regardless of chipselect (read latency 1): addr0 s, addr1 0, addr2 irqmask, addr3 edgecapture, zero-extended.
- Writes to addresses 0 and 1 have no effect.

## Timing
- Reset values: readdata 0, irq 0, irqmask 0, edgecapture 0, sync chain 0, prev 0, arming counter 0.
- in_port transition before edge 1 -> s changes after edge SYNC_STAGES; edgecapture bit and irq assert after edge SYNC_STAGES+1; readdata at address 0 shows new value after edge SYNC_STAGES+1.
- Register write takes effect at the clock edge it is sampled; irq reflects new mask/capture from that edge.
- Read latency exactly 1 clock: readdata at edge k+1 reflects address presented before edge k+1 and register state before that edge.
- Input pulses shorter than one clk period may be missed; no guarantee.
- reset_n asserted mid-operation clears everything immediately (async); deassertion restarts arming.

## Test plan
- Reset with in_port=all ones, WIDTH=2: after release, edgecapture stays 0, irq 0; address 0 reads 0x3 from edge SYNC_STAGES+1 on.
- EDGE_TYPE=0: irqmask=0x1, pulse in_port[0] 0->1 for 3 cycles -> edgecapture=0x1 and irq=1 at edge SYNC_STAGES+1; falling edge does not clear it.
- Write 0x1 to address 3 with BIT_CLEAR=1 while bit1 also set -> edgecapture becomes 0x2; irq drops if mask=0x1.
- Edge on bit0 in same cycle as clear write of 0x1 -> edgecapture bit0 remains 1, irq stays 1.
- EDGE_TYPE=2, mask=0x3: toggle in_port[1] twice -> bit1 set after first toggle; masked with irqmask=0 -> irq 0 while edgecapture=0x2.
- Assert reset_n mid-capture with edgecapture=0x3, irqmask=0x3 -> irq, readdata, registers 0 immediately; no capture during re-arm window.
